// File: rtl/enigma_pkg.sv
// Shared Enigma datapath types and constants: alphabet size, position width,
// default rotor notches and the rotor stepper state encoding.
package enigma_pkg;

  localparam int NUM_LETTERS = 26;
  localparam int POS_W       = 6;

  typedef logic [POS_W-1:0] pos_t;

  // Turnover positions for rotors I (Q), II (E) and III (V).
  localparam pos_t NOTCH_L = pos_t'(16);
  localparam pos_t NOTCH_M = pos_t'(4);
  localparam pos_t NOTCH_R = pos_t'(21);

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    PRESENT
  } stepper_state_t;

  function automatic logic pos_in_range(input pos_t p);
    return p < pos_t'(NUM_LETTERS);
  endfunction

endpackage

// File: rtl/rotor_wheel_counter.sv
// Single rotor position: mod-26 counter with synchronous load and step,
// flagging when the wheel sits on its turnover notch.
module rotor_wheel_counter
  import enigma_pkg::*;
#(
  parameter pos_t NOTCH = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  pos_t load_val,
  input  logic step_en,
  output pos_t pos,
  output logic at_notch
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
    end else if (load) begin
      pos <= load_val;
    end else if (step_en) begin
      pos <= (pos == pos_t'(NUM_LETTERS - 1)) ? '0 : pos + pos_t'(1);
    end
  end

  assign at_notch = (pos == NOTCH);

endmodule

// File: rtl/rotor_stepper.sv
// Three-rotor Enigma stepping controller with ready/valid pacing.
// Optional historical double-step: define ROTOR_STEPPER_DOUBLE_STEP_EN.
module rotor_stepper
  import enigma_pkg::*;
#(
  parameter pos_t NOTCH_L = enigma_pkg::NOTCH_L,
  parameter pos_t NOTCH_M = enigma_pkg::NOTCH_M,
  parameter pos_t NOTCH_R = enigma_pkg::NOTCH_R
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [POS_W-1:0] load_pos_l,
  input  logic [POS_W-1:0] load_pos_m,
  input  logic [POS_W-1:0] load_pos_r,
  output logic             load_err,
  input  logic             key_valid,
  output logic             key_ready,
  output logic             pos_valid,
  input  logic             pos_ready,
  output logic [POS_W-1:0] pos_l,
  output logic [POS_W-1:0] pos_m,
  output logic [POS_W-1:0] pos_r
);

  stepper_state_t state_q, state_d;

  logic load_take, load_ok, load_wr;
  logic step_l, step_m, step_r;
  logic m_at, r_at;
  logic l_at_notch_unused;

  // Loads are only honoured while idle; other states ignore load_en entirely.
  assign load_take = (state_q == IDLE) && load_en;
  assign load_ok   = pos_in_range(load_pos_l) && pos_in_range(load_pos_m) &&
                     pos_in_range(load_pos_r);
  assign load_wr   = load_take && load_ok;

  // Stepping is decided on the pre-step positions, all wheels move together.
  assign step_r = (state_q == STEP);
`ifdef ROTOR_STEPPER_DOUBLE_STEP_EN
  assign step_m = step_r && (r_at || m_at);
`else
  assign step_m = step_r && r_at;
`endif
  assign step_l = step_m && m_at;

  // NOTCH_L has no stepping role yet; it is carried for a future fourth rotor.
  rotor_wheel_counter #(.NOTCH(NOTCH_L)) u_wheel_l (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_wr),
    .load_val (load_pos_l),
    .step_en  (step_l),
    .pos      (pos_l),
    .at_notch (l_at_notch_unused)
  );

  rotor_wheel_counter #(.NOTCH(NOTCH_M)) u_wheel_m (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_wr),
    .load_val (load_pos_m),
    .step_en  (step_m),
    .pos      (pos_m),
    .at_notch (m_at)
  );

  rotor_wheel_counter #(.NOTCH(NOTCH_R)) u_wheel_r (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_wr),
    .load_val (load_pos_r),
    .step_en  (step_r),
    .pos      (pos_r),
    .at_notch (r_at)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      load_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      load_err <= load_take && !load_ok;
    end
  end

  // NOTE: state_d is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!load_en && key_valid) state_d = STEP;
      STEP:    state_d = PRESENT;
      PRESENT: if (pos_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign key_ready = (state_q == IDLE);
  assign pos_valid = (state_q == PRESENT);

endmodule

// File: tb/tb_rotor_stepper.sv
// Self-checking bench for rotor_stepper: directed vector table, hand-written
// multi-cycle corner sequences and randomized traffic against a letter model.
module tb_rotor_stepper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_en = 1'b0;
  logic [5:0] load_pos_l = '0, load_pos_m = '0, load_pos_r = '0;
  logic       load_err;
  logic       key_valid = 1'b0;
  logic       key_ready;
  logic       pos_valid;
  logic       pos_ready = 1'b0;
  logic [5:0] pos_l, pos_m, pos_r;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference rotor letters (0..25).
  int ml = 0, mm = 0, mr = 0;

  rotor_stepper dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .load_pos_l (load_pos_l),
    .load_pos_m (load_pos_m),
    .load_pos_r (load_pos_r),
    .load_err   (load_err),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .pos_valid  (pos_valid),
    .pos_ready  (pos_ready),
    .pos_l      (pos_l),
    .pos_m      (pos_m),
    .pos_r      (pos_r)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
    end
  endtask

  task automatic check_pos(input string name, input int el, input int em, input int er);
    check({name, ".pos_l"}, 32'(pos_l), el);
    check({name, ".pos_m"}, 32'(pos_m), em);
    check({name, ".pos_r"}, 32'(pos_r), er);
  endtask

  // Enigma stepping rules expressed on letters: right always turns, the
  // middle turns when the right passes V (or, double-stepping, when the
  // middle itself sits on E), and the left turns with a middle leaving E.
  function automatic void model_step();
    bit r_at, m_at, mid;
    r_at = (mr == 21);
    m_at = (mm == 4);
    mid  = r_at;
`ifdef ROTOR_STEPPER_DOUBLE_STEP_EN
    mid  = r_at || m_at;
`endif
    if (mid && m_at) ml = (ml + 1) % 26;
    if (mid) mm = (mm + 1) % 26;
    mr = (mr + 1) % 26;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string name, input int l, input int m, input int r,
                         input int el, input int em, input int er, input int eerr);
    load_en = 1'b1;
    load_pos_l = 6'(l);
    load_pos_m = 6'(m);
    load_pos_r = 6'(r);
    tick();
    load_en = 1'b0;
    check({name, ".load_err"}, 32'(load_err), eerr);
    check({name, ".key_ready"}, 32'(key_ready), 1);
    check_pos(name, el, em, er);
    tick();
    check({name, ".load_err_clr"}, 32'(load_err), 0);
  endtask

  // Accept one key, verify the two-cycle latency, hold pos_ready low for
  // `hold` cycles, then complete the handshake.
  task automatic do_key(input string name, input int hold,
                        input int el, input int em, input int er);
    int sl, sm, sr;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    check({name, ".step_valid"}, 32'(pos_valid), 0);
    check({name, ".step_ready"}, 32'(key_ready), 0);
    tick();
    check({name, ".pos_valid"}, 32'(pos_valid), 1);
    check_pos(name, el, em, er);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({name, ".hold_valid"}, 32'(pos_valid), 1);
      check_pos({name, ".hold"}, el, em, er);
    end
    pos_ready = 1'b1;
    tick();
    pos_ready = 1'b0;
    check({name, ".done_ready"}, 32'(key_ready), 1);
    check({name, ".done_valid"}, 32'(pos_valid), 0);
  endtask

  typedef struct {
    bit is_load;
    int l, m, r;
    int el, em, er;
    int eerr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cnt;
    // Directed table: first key after reset, double-step walk, wrap, bad load.
    vecs[0] = '{0, 0, 0, 0, 0, 0, 1, 0};
    vecs[1] = '{1, 0, 3, 20, 0, 3, 20, 0};
    vecs[2] = '{0, 0, 0, 0, 0, 3, 21, 0};
    vecs[3] = '{0, 0, 0, 0, 0, 4, 22, 0};
`ifdef ROTOR_STEPPER_DOUBLE_STEP_EN
    vecs[4] = '{0, 0, 0, 0, 1, 5, 23, 0};
`else
    vecs[4] = '{0, 0, 0, 0, 0, 4, 23, 0};
`endif
    vecs[5] = '{1, 25, 25, 25, 25, 25, 25, 0};
    vecs[6] = '{0, 0, 0, 0, 25, 25, 0, 0};
    vecs[7] = '{1, 5, 26, 5, 25, 25, 0, 1};

    #12;
    check("rst.pos_valid", 32'(pos_valid), 0);
    check("rst.load_err", 32'(load_err), 0);
    check("rst.key_ready", 32'(key_ready), 1);
    check_pos("rst", 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_load)
        do_load($sformatf("vec%0d", i), vecs[i].l, vecs[i].m, vecs[i].r,
                vecs[i].el, vecs[i].em, vecs[i].er, vecs[i].eerr);
      else
        do_key($sformatf("vec%0d", i), 0, vecs[i].el, vecs[i].em, vecs[i].er);
    end
    ml = 25; mm = 25; mr = 0;

    // Rejected load with a simultaneous key: neither is taken.
    load_en = 1'b1; load_pos_l = 6'd1; load_pos_m = 6'd26; load_pos_r = 6'd1;
    key_valid = 1'b1;
    tick();
    load_en = 1'b0; key_valid = 1'b0;
    check("badld.load_err", 32'(load_err), 1);
    check("badld.key_ready", 32'(key_ready), 1);
    check_pos("badld", 25, 25, 0);
    tick();
    check("badld.err_clr", 32'(load_err), 0);
    check("badld.no_step", 32'(pos_valid), 0);
    check("badld.idle", 32'(key_ready), 1);

    // Backpressure: key and load pulses are dropped while presenting.
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    tick();
    check("bp.valid", 32'(pos_valid), 1);
    check_pos("bp", 25, 25, 1);
    for (int i = 0; i < 5; i++) begin
      key_valid = 1'b1;
      load_en = 1'b1; load_pos_l = 6'd1; load_pos_m = 6'd2; load_pos_r = 6'd3;
      tick();
      check("bp.hold_valid", 32'(pos_valid), 1);
      check("bp.hold_ready", 32'(key_ready), 0);
      check("bp.hold_err", 32'(load_err), 0);
      check_pos("bp.hold", 25, 25, 1);
    end
    key_valid = 1'b0; load_en = 1'b0; pos_ready = 1'b1;
    tick();
    pos_ready = 1'b0;
    check("bp.release_ready", 32'(key_ready), 1);
    tick();
    check("bp.no_extra_step", 32'(pos_valid), 0);
    check_pos("bp.after", 25, 25, 1);

    // Reset while presenting clears everything immediately.
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    tick();
    check_pos("rstp.pre", 25, 25, 2);
    #2 rst_n = 1'b0;
    #1;
    check("rstp.valid", 32'(pos_valid), 0);
    check("rstp.ready", 32'(key_ready), 1);
    check_pos("rstp", 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("rstp.after_ready", 32'(key_ready), 1);
    check("rstp.after_valid", 32'(pos_valid), 0);

    // Reset mid-STEP aborts the key: no pos_valid ever shows for it.
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_pos("rsts", 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rsts.no_valid", 32'(pos_valid), 0);
    end
    ml = 0; mm = 0; mr = 0;

    // Throughput with pos_ready tied high: three keys in nine cycles.
    pos_ready = 1'b1;
    key_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (pos_valid) cnt++;
    end
    key_valid = 1'b0;
    pos_ready = 1'b0;
    for (int i = 0; i < 3; i++) model_step();
    check("thru.count", 32'(cnt), 3);
    check_pos("thru", ml, mm, mr);
    tick();

    // Randomized traffic against the letter model.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        int l, m, r, err;
        l = $urandom_range(0, 29);
        m = $urandom_range(0, 29);
        r = $urandom_range(0, 29);
        err = (l > 25 || m > 25 || r > 25) ? 1 : 0;
        if (err == 0) begin
          ml = l; mm = m; mr = r;
        end
        do_load($sformatf("rnd%0d", i), l, m, r, ml, mm, mr, err);
      end else begin
        model_step();
        do_key($sformatf("rnd%0d", i), int'($urandom_range(0, 3)), ml, mm, mr);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
